serial_subtractor: RTL and testbench

Digit-serial two's-complement subtractor for the ALU datapath. It computes `a - b - bin` over `W` bits, four bits per clock, using a carry-skip digit stage. A ready/valid handshake sits on both the operand and result sides, and the result stays registered until it is consumed. It is the area-lean counterpart of the combinational carry-skip adder chain: the mantissa/exponent difference paths use it when one operation every few cycles is sufficient.

---
 rtl/serial_subtractor.sv | 169 ++++++++++++++++
 tb/tb_serial_subtractor.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/serial_subtractor.sv
// serial_subtractor: digit-serial two's-complement subtractor, four bits per clock.
// Computes (a - b - bin) mod 2^W LSB digit first, through a carry-skip digit stage.
// A ready/valid handshake sits on both sides. The result stays registered until it is consumed.
// Optional feature macro: SERIAL_SUB_ADD_MODE_EN adds an `op` input that selects add (1) or subtract (0).
module serial_subtractor #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         bin,
`ifdef SERIAL_SUB_ADD_MODE_EN
    input  logic         op,
`endif
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] diff,
    output logic         bout,
    output logic         zero
);

    localparam int N     = W / 4;
    localparam int CNT_W = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_BUSY,
        S_DONE
    } state_t;

    state_t             r_state;
    logic [W-1:0]       r_a;
    logic [W-1:0]       r_b;
    logic               r_carry;
    logic [CNT_W-1:0]   r_cnt;
    logic [W-1:0]       r_diff;
    logic               r_bout;
    logic               r_zero;
    logic               r_in_ready;
    logic               r_out_valid;

    logic [4:0]         w_digit;
    logic [W-1:0]       w_diff_next;
    logic [W-1:0]       w_b_load;
    logic               w_carry_load;
    logic               w_last;

    // One 4-bit digit with carry-skip.
    // When every propagate bit is set, the incoming carry bypasses the ripple chain.
    function automatic logic [4:0] digit_add(input logic [3:0] x, input logic [3:0] y,
                                             input logic cin);
        logic [3:0] p;
        logic [3:0] g;
        logic [4:0] c;
        p    = x ^ y;
        g    = x & y;
        c    = '0;
        c[0] = cin;
        for (int i = 0; i < 4; i++) begin
            c[i+1] = g[i] | (p[i] & c[i]);
        end
        return {((&p) ? cin : c[4]), (p ^ c[3:0])};
    endfunction

    // Subtraction is addition of the inverted subtrahend with an inverted borrow as carry-in.
`ifdef SERIAL_SUB_ADD_MODE_EN
    assign w_b_load     = op ? b : ~b;
    assign w_carry_load = op ? bin : ~bin;
`else
    assign w_b_load     = ~b;
    assign w_carry_load = ~bin;
`endif

    assign w_digit = digit_add(r_a[3:0], r_b[3:0], r_carry);
    assign w_last  = (r_cnt == CNT_W'(N - 1));

    // The new sum digit enters the result register at the MSB end.
    // After N shifts, digit 0 has reached the LSB position.
    generate
        if (W == 4) begin : g_diff_single
            assign w_diff_next = w_digit[3:0];
        end else begin : g_diff_shift
            assign w_diff_next = {w_digit[3:0], r_diff[W-1:4]};
        end
    endgenerate

    // Handshake FSM and digit datapath.
    // Outputs are registered, so the result holds stable in DONE.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_a         <= '0;
            r_b         <= '0;
            r_carry     <= 1'b0;
            r_cnt       <= '0;
            r_diff      <= '0;
            r_bout      <= 1'b0;
            r_zero      <= 1'b0;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (in_valid && r_in_ready) begin
                        r_a        <= a;
                        r_b        <= w_b_load;
                        r_carry    <= w_carry_load;
                        r_cnt      <= '0;
                        r_in_ready <= 1'b0;
                        r_state    <= S_BUSY;
                    end
                end
                S_BUSY: begin
                    r_a     <= r_a >> 4;
                    r_b     <= r_b >> 4;
                    r_carry <= w_digit[4];
                    r_diff  <= w_diff_next;
                    if (w_last) begin
                        r_bout      <= ~w_digit[4];
                        r_zero      <= ~(|w_diff_next);
                        r_out_valid <= 1'b1;
                        r_state     <= S_DONE;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                S_DONE: begin
                    if (r_out_valid && out_ready) begin
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                        r_state     <= S_IDLE;
                    end
                end
                default: begin
                    r_out_valid <= 1'b0;
                    r_in_ready  <= 1'b1;
                    r_state     <= S_IDLE;
                end
            endcase
        end
    end

`ifdef SERIAL_SUB_ADD_MODE_EN
    // In add mode, the final carry itself is the carry-out, so undo the borrow inversion.
    logic r_op;

    // Remember the mode of the in-flight operation.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_op <= 1'b0;
        end else if (r_state == S_IDLE && in_valid && r_in_ready) begin
            r_op <= op;
        end
    end

    assign bout = r_op ? ~r_bout : r_bout;
`else
    assign bout = r_bout;
`endif

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign diff      = r_diff;
    assign zero      = r_zero;

endmodule

// File: tb/tb_serial_subtractor.sv
// Bench for serial_subtractor (W=32).
// Runs a table of directed subtract vectors, followed by backpressure, mid-operation reset and add-mode sequences.
module tb_serial_subtractor;

    localparam int W = 32;
    localparam int N = W / 4;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         bin;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] diff;
    logic         bout;
    logic         zero;
`ifdef SERIAL_SUB_ADD_MODE_EN
    logic         op;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    serial_subtractor #(.W(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .bin       (bin),
`ifdef SERIAL_SUB_ADD_MODE_EN
        .op        (op),
`endif
        .out_valid (out_valid),
        .out_ready (out_ready),
        .diff      (diff),
        .bout      (bout),
        .zero      (zero)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         bin;
        logic [W-1:0] diff;
        logic         bout;
        logic         zero;
    } vec_t;

    vec_t vecs[11];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Wait for in_ready, present the operands for one edge, then scramble the inputs.
    task automatic accept(input logic [W-1:0] va, input logic [W-1:0] vb, input logic vbin);
        int guard;
        guard = 0;
        while (!in_ready && guard < 20) begin
            tick();
            guard++;
        end
        check("in_ready_before_accept", {31'd0, in_ready}, 32'd1);
        a        = va;
        b        = vb;
        bin      = vbin;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        a        = 32'hDEADBEEF;
        b        = 32'h13579BDF;
        bin      = ~vbin;
    endtask

    // Count edges from acceptance until out_valid rises, within a fixed cycle bound.
    task automatic wait_result(output int lat);
        lat = 0;
        while (!out_valid && lat < 20) begin
            tick();
            lat++;
            if (lat == 1) check("in_ready_busy", {31'd0, in_ready}, 32'd0);
        end
        if (!out_valid) begin
            n_checks++;
            n_fail++;
            $display("FAIL timeout: out_valid not seen after %0d cycles", lat);
        end
    endtask

    initial begin
        int lat;
        logic [W-1:0] held;

        vecs[0]  = '{32'h00000005, 32'h00000003, 1'b0, 32'h00000002, 1'b0, 1'b0};
        vecs[1]  = '{32'h00000000, 32'h00000000, 1'b1, 32'hFFFFFFFF, 1'b1, 1'b0};
        vecs[2]  = '{32'h12345678, 32'h12345678, 1'b0, 32'h00000000, 1'b0, 1'b1};
        vecs[3]  = '{32'h80000000, 32'h00000001, 1'b0, 32'h7FFFFFFF, 1'b0, 1'b0};
        vecs[4]  = '{32'h00000003, 32'h00000005, 1'b0, 32'hFFFFFFFE, 1'b1, 1'b0};
        vecs[5]  = '{32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 32'hFFFFFFFF, 1'b1, 1'b0};
        vecs[6]  = '{32'h00000010, 32'h0000000F, 1'b1, 32'h00000000, 1'b0, 1'b1};
        vecs[7]  = '{32'h00000000, 32'hFFFFFFFF, 1'b0, 32'h00000001, 1'b1, 1'b0};
        vecs[8]  = '{32'hFFFFFFFF, 32'h00000000, 1'b0, 32'hFFFFFFFF, 1'b0, 1'b0};
        vecs[9]  = '{32'hA5A5A5A5, 32'h5A5A5A5A, 1'b0, 32'h4B4B4B4B, 1'b0, 1'b0};
        vecs[10] = '{32'h00000100, 32'h00000001, 1'b1, 32'h000000FE, 1'b0, 1'b0};

        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        a         = '0;
        b         = '0;
        bin       = 1'b0;
`ifdef SERIAL_SUB_ADD_MODE_EN
        op        = 1'b0;
`endif
        tick();
        tick();
        rst = 1'b0;

        // Values coming out of reset
        check("rst_in_ready", {31'd0, in_ready}, 32'd1);
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_diff", diff, 32'd0);
        check("rst_bout", {31'd0, bout}, 32'd0);
        check("rst_zero", {31'd0, zero}, 32'd0);

        // Table-driven subtract vectors, with out_ready held high
        for (int i = 0; i < 11; i++) begin
            accept(vecs[i].a, vecs[i].b, vecs[i].bin);
            wait_result(lat);
            check($sformatf("latency[%0d]", i), lat, N);
            check($sformatf("diff[%0d]", i), diff, vecs[i].diff);
            check($sformatf("bout[%0d]", i), {31'd0, bout}, {31'd0, vecs[i].bout});
            check($sformatf("zero[%0d]", i), {31'd0, zero}, {31'd0, vecs[i].zero});
            check($sformatf("in_ready_done[%0d]", i), {31'd0, in_ready}, 32'd0);
            tick();
            check($sformatf("out_valid_after_hs[%0d]", i), {31'd0, out_valid}, 32'd0);
            check($sformatf("in_ready_after_hs[%0d]", i), {31'd0, in_ready}, 32'd1);
        end

        // Backpressure: the result must hold for 5 cycles of out_ready=0
        out_ready = 1'b0;
        accept(32'h80000000, 32'h00000001, 1'b0);
        wait_result(lat);
        check("bp_latency", lat, N);
        held = diff;
        check("bp_diff", diff, 32'h7FFFFFFF);
        in_valid = 1'b1;
        for (int k = 0; k < 5; k++) begin
            tick();
            check($sformatf("bp_hold_valid[%0d]", k), {31'd0, out_valid}, 32'd1);
            check($sformatf("bp_hold_ready[%0d]", k), {31'd0, in_ready}, 32'd0);
            check($sformatf("bp_hold_diff[%0d]", k), diff, held);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick();
        check("bp_release_valid", {31'd0, out_valid}, 32'd0);
        check("bp_release_ready", {31'd0, in_ready}, 32'd1);

        // Reset asserted during the third BUSY cycle
        accept(32'h00000009, 32'h00000004, 1'b0);
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("midrst_in_ready", {31'd0, in_ready}, 32'd1);
        check("midrst_out_valid", {31'd0, out_valid}, 32'd0);
        check("midrst_diff", diff, 32'd0);
        for (int k = 0; k < 10; k++) begin
            tick();
            check($sformatf("midrst_quiet[%0d]", k), {31'd0, out_valid}, 32'd0);
        end

        // Normal operation after the reset
        accept(32'h00000009, 32'h00000004, 1'b0);
        wait_result(lat);
        check("post_rst_diff", diff, 32'h00000005);
        check("post_rst_bout", {31'd0, bout}, 32'd0);
        tick();

`ifdef SERIAL_SUB_ADD_MODE_EN
        // Add mode: the carry out of the top digit sets bout
        op = 1'b1;
        accept(32'hFFFFFFFF, 32'h00000001, 1'b0);
        wait_result(lat);
        check("add_diff", diff, 32'h00000000);
        check("add_bout", {31'd0, bout}, 32'd1);
        check("add_zero", {31'd0, zero}, 32'd1);
        tick();
        accept(32'h00000002, 32'h00000003, 1'b1);
        wait_result(lat);
        check("add2_diff", diff, 32'h00000006);
        check("add2_bout", {31'd0, bout}, 32'd0);
        tick();
        op = 1'b0;
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
